// File: rtl/tx_source_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tx_source_scheduler_pkg
// Shared definitions for the TX source scheduler and the UDP packet composer:
//   - kv_select_e   : record type carried alongside every {key,val} record
//   - sched_state_e : scheduler FSM states
//   - pick_source() : arbitration between the three KV sources
// ---------------------------------------------------------------------------
package tx_source_scheduler_pkg;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_PUT    = 2'd1,
        SEL_FLUSH  = 2'd2,
        SEL_TCHECK = 2'd3
    } kv_select_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_OFFER   = 3'd3,
        ST_GAP     = 3'd4
    } sched_state_e;

    // TCHECK always wins. FLUSH and PUT share the remaining bandwidth:
    // when both request, the one that did not win the previous bulk
    // grant goes next, so neither bulk source can starve the other.
    function automatic kv_select_e pick_source(
        input logic       req_t,
        input logic       req_f,
        input logic       req_p,
        input kv_select_e last_bulk
    );
        if (req_t) begin
            return SEL_TCHECK;
        end else if (req_f && req_p) begin
            return (last_bulk == SEL_PUT) ? SEL_FLUSH : SEL_PUT;
        end else if (req_f) begin
            return SEL_FLUSH;
        end else if (req_p) begin
            return SEL_PUT;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/tx_source_scheduler_interpkt_gap_timer.sv
// ---------------------------------------------------------------------------
// tx_source_scheduler_interpkt_gap_timer
// Loadable down-counter that times the inter-packet gap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load count with load_value (takes priority over count_en)
//   load_value  : gap length in cycles
//   count_en    : decrement by one while the count is non-zero
//   zero        : count currently reads zero
// ---------------------------------------------------------------------------
module tx_source_scheduler_interpkt_gap_timer #(
    parameter int GAP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [GAP_WIDTH-1:0] load_value,
    input  logic                 count_en,
    output logic                 zero
);

    logic [GAP_WIDTH-1:0] count;

    // The count never goes below zero, so a stray enable at zero is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tx_source_scheduler.sv
// ---------------------------------------------------------------------------
// tx_source_scheduler
// Arbitrates the single UDP packet composer between three KV source FIFOs
// (TCHECK accumulate values, DRAM FLUSH, external PUT updates). It pops one
// entry from the winner, presents it as a {key,val,select} record and,
// after the composer takes it, waits the programmed inter-packet gap.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   tcheck_q/_empty/_rdreq          : accum FIFO (32-bit value, 1-cycle latency)
//   flush_q/_empty/_rdreq           : DRAM FIFO ({key,val}, 1-cycle latency)
//   put_q/_empty/_rdreq             : TX update FIFO ({key,val}, 1-cycle latency)
//   start_update                    : level enable for PUT requests
//   interpkt_gap_cycles             : gap length, sampled at the handshake
//   kv_valid/kv_ready               : record handshake to the composer
//   kv_key/kv_val/kv_select         : record payload and type
//   busy                            : scheduler is not idle
//   grant_cnt_tcheck/_flush/_put    : saturating per-source grant counters
// ---------------------------------------------------------------------------
module tx_source_scheduler
    import tx_source_scheduler_pkg::*;
#(
    parameter int KEY_WIDTH  = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int GAP_WIDTH  = 32,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           tcheck_q,
    input  logic                  tcheck_empty,
    output logic                  tcheck_rdreq,
    input  logic [63:0]           flush_q,
    input  logic                  flush_empty,
    output logic                  flush_rdreq,
    input  logic [63:0]           put_q,
    input  logic                  put_empty,
    output logic                  put_rdreq,
    input  logic                  start_update,
    input  logic [GAP_WIDTH-1:0]  interpkt_gap_cycles,
    output logic                  kv_valid,
    input  logic                  kv_ready,
    output logic [KEY_WIDTH-1:0]  kv_key,
    output logic [VAL_WIDTH-1:0]  kv_val,
    output logic [1:0]            kv_select,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] grant_cnt_tcheck,
    output logic [STAT_WIDTH-1:0] grant_cnt_flush,
    output logic [STAT_WIDTH-1:0] grant_cnt_put
);

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    sched_state_e state;
    sched_state_e next_state;
    kv_select_e   sel_q;
    kv_select_e   last_bulk;
    kv_select_e   grant;

    logic req_t;
    logic req_f;
    logic req_p;
    logic handshake;
    logic gap_load;
    logic gap_count_en;
    logic gap_zero;

    assign req_t = !tcheck_empty;
    assign req_f = !flush_empty;
    assign req_p = !put_empty && start_update;

    assign grant     = pick_source(req_t, req_f, req_p, last_bulk);
    assign handshake = (state == ST_OFFER) && kv_ready;

    tx_source_scheduler_interpkt_gap_timer #(
        .GAP_WIDTH (GAP_WIDTH)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (interpkt_gap_cycles),
        .count_en   (gap_count_en),
        .zero       (gap_zero)
    );

    // Next-state and output decode. Requests are only looked at in IDLE,
    // so anything arriving mid-record waits for the next arbitration.
    always_comb begin
        next_state   = state;
        gap_load     = 1'b0;
        gap_count_en = 1'b0;
        tcheck_rdreq = 1'b0;
        flush_rdreq  = 1'b0;
        put_rdreq    = 1'b0;
        kv_valid     = 1'b0;
        kv_select    = SEL_NONE;
        busy         = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (grant != SEL_NONE) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                tcheck_rdreq = (sel_q == SEL_TCHECK);
                flush_rdreq  = (sel_q == SEL_FLUSH);
                put_rdreq    = (sel_q == SEL_PUT);
                kv_select    = sel_q;
                next_state   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                kv_select  = sel_q;
                next_state = ST_OFFER;
            end
            ST_OFFER: begin
                kv_valid  = 1'b1;
                kv_select = sel_q;
                if (kv_ready) begin
                    gap_load   = 1'b1;
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                // The counter reads N on the first GAP cycle, so the state
                // lasts N+1 cycles in total.
                if (gap_zero) begin
                    next_state = ST_IDLE;
                end else begin
                    gap_count_en = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register plus grant bookkeeping. last_bulk starts at PUT so the
    // first FLUSH/PUT tie after reset goes to FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= SEL_NONE;
            last_bulk <= SEL_PUT;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && (grant != SEL_NONE)) begin
                sel_q <= grant;
                if (grant != SEL_TCHECK) begin
                    last_bulk <= grant;
                end
            end
        end
    end

    // Record capture one cycle after the pop, when the FIFO's q is valid.
    // The record is then held untouched through OFFER. An empty FIFO at pop
    // time is a source fault; whatever q shows is forwarded regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            kv_key <= '0;
            kv_val <= '0;
        end else if (state == ST_CAPTURE) begin
            case (sel_q)
                SEL_TCHECK: begin
                    kv_key <= '0;
                    kv_val <= tcheck_q;
                end
                SEL_FLUSH: begin
                    kv_key <= flush_q[63:32];
                    kv_val <= flush_q[31:0];
                end
                SEL_PUT: begin
                    kv_key <= put_q[63:32];
                    kv_val <= put_q[31:0];
                end
                default: begin
                    kv_key <= kv_key;
                    kv_val <= kv_val;
                end
            endcase
        end
    end

    // Per-source grant statistics, counted at the composer handshake and
    // pinned at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_tcheck <= '0;
            grant_cnt_flush  <= '0;
            grant_cnt_put    <= '0;
        end else if (handshake) begin
            if ((sel_q == SEL_TCHECK) && (grant_cnt_tcheck != STAT_MAX)) begin
                grant_cnt_tcheck <= grant_cnt_tcheck + 1'b1;
            end
            if ((sel_q == SEL_FLUSH) && (grant_cnt_flush != STAT_MAX)) begin
                grant_cnt_flush <= grant_cnt_flush + 1'b1;
            end
            if ((sel_q == SEL_PUT) && (grant_cnt_put != STAT_MAX)) begin
                grant_cnt_put <= grant_cnt_put + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_source_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_source_scheduler
// Self-checking bench for tx_source_scheduler. Behavioural FIFO models feed
// the three sources; expected records are queued when entries are pushed and
// checked in order as the composer handshake fires.
// ---------------------------------------------------------------------------
module tb_tx_source_scheduler;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int GW = 32;
    localparam int SW = 4;

    typedef struct {
        logic [31:0] key;
        logic [31:0] val;
        logic [1:0]  sel;
    } rec_t;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic [31:0]   tcheck_q     = '0;
    logic          tcheck_empty = 1'b1;
    logic          tcheck_rdreq;
    logic [63:0]   flush_q      = '0;
    logic          flush_empty  = 1'b1;
    logic          flush_rdreq;
    logic [63:0]   put_q        = '0;
    logic          put_empty    = 1'b1;
    logic          put_rdreq;
    logic          start_update = 1'b0;
    logic [GW-1:0] interpkt_gap_cycles = '0;
    logic          kv_valid;
    logic          kv_ready     = 1'b0;
    logic [KW-1:0] kv_key;
    logic [VW-1:0] kv_val;
    logic [1:0]    kv_select;
    logic          busy;
    logic [SW-1:0] grant_cnt_tcheck;
    logic [SW-1:0] grant_cnt_flush;
    logic [SW-1:0] grant_cnt_put;

    rec_t        sb[$];
    logic [31:0] tq[$];
    logic [63:0] fq[$];
    logic [63:0] pq[$];
    int          hs_times[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    tx_source_scheduler #(
        .KEY_WIDTH  (KW),
        .VAL_WIDTH  (VW),
        .GAP_WIDTH  (GW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .tcheck_q            (tcheck_q),
        .tcheck_empty        (tcheck_empty),
        .tcheck_rdreq        (tcheck_rdreq),
        .flush_q             (flush_q),
        .flush_empty         (flush_empty),
        .flush_rdreq         (flush_rdreq),
        .put_q               (put_q),
        .put_empty           (put_empty),
        .put_rdreq           (put_rdreq),
        .start_update        (start_update),
        .interpkt_gap_cycles (interpkt_gap_cycles),
        .kv_valid            (kv_valid),
        .kv_ready            (kv_ready),
        .kv_key              (kv_key),
        .kv_val              (kv_val),
        .kv_select           (kv_select),
        .busy                (busy),
        .grant_cnt_tcheck    (grant_cnt_tcheck),
        .grant_cnt_flush     (grant_cnt_flush),
        .grant_cnt_put       (grant_cnt_put)
    );

    always #5 clk = ~clk;

    // FIFO models: a pop at the clock edge presents the head on q for the
    // following cycle; empty follows the queue occupancy after that edge.
    task automatic fifo_model();
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (tcheck_rdreq && tq.size() != 0) tcheck_q <= tq.pop_front();
            if (flush_rdreq && fq.size() != 0) flush_q <= fq.pop_front();
            if (put_rdreq && pq.size() != 0) put_q <= pq.pop_front();
            tcheck_empty <= (tq.size() == 0);
            flush_empty  <= (fq.size() == 0);
            put_empty    <= (pq.size() == 0);
        end
    endtask

    // Continuous checks: rdreq exclusivity, select idle value, and in-order
    // scoreboard comparison at every composer handshake.
    task automatic monitor();
        rec_t exp_rec;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tests++;
                if (($countones({tcheck_rdreq, flush_rdreq, put_rdreq}) > 1) ||
                    ((tcheck_rdreq || flush_rdreq || put_rdreq) && (!busy || kv_valid))) begin
                    fails++;
                    $display("[TB] FAIL rdreq_exclusive cyc=%0d: got t/f/p=%b%b%b busy=%b valid=%b, required at most one rdreq and only while reading",
                             cyc, tcheck_rdreq, flush_rdreq, put_rdreq, busy, kv_valid);
                end
                tests++;
                if (!busy && kv_select !== 2'd0) begin
                    fails++;
                    $display("[TB] FAIL select_idle cyc=%0d: got %0d, required 0", cyc, kv_select);
                end
                if (kv_valid && kv_ready) begin
                    hs_times.push_back(cyc);
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL record_unexpected cyc=%0d: got key=%h val=%h sel=%0d, required no record",
                                 cyc, kv_key, kv_val, kv_select);
                    end else begin
                        exp_rec = sb.pop_front();
                        if (kv_key !== exp_rec.key || kv_val !== exp_rec.val || kv_select !== exp_rec.sel) begin
                            fails++;
                            $display("[TB] FAIL record cyc=%0d: got key=%h val=%h sel=%0d, required key=%h val=%h sel=%0d",
                                     cyc, kv_key, kv_val, kv_select, exp_rec.key, exp_rec.val, exp_rec.sel);
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] key, input logic [31:0] val, input logic [1:0] sel);
        rec_t r;
        r.key = key;
        r.val = val;
        r.sel = sel;
        sb.push_back(r);
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0 || busy) begin
            fails++;
            $display("[TB] FAIL %s_drain: got pending=%0d busy=%b, required pending=0 busy=0", name, sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!kv_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!kv_valid) begin
            fails++;
            $display("[TB] FAIL %s_valid_timeout: got kv_valid=0, required 1", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (kv_valid !== 1'b0 || kv_key !== '0 || kv_val !== '0 || kv_select !== 2'd0 || busy !== 1'b0 ||
            tcheck_rdreq !== 1'b0 || flush_rdreq !== 1'b0 || put_rdreq !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_outputs: got valid=%b key=%h val=%h sel=%0d busy=%b rd=%b%b%b, required all zero",
                     name, kv_valid, kv_key, kv_val, kv_select, busy, tcheck_rdreq, flush_rdreq, put_rdreq);
        end
        tests++;
        if (grant_cnt_tcheck !== '0 || grant_cnt_flush !== '0 || grant_cnt_put !== '0) begin
            fails++;
            $display("[TB] FAIL %s_counters: got t=%0d f=%0d p=%0d, required 0 0 0",
                     name, grant_cnt_tcheck, grant_cnt_flush, grant_cnt_put);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        @(negedge clk);
        check_reset_outputs("reset_held");
        step();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    // Everything pending at once: TCHECK first, then FLUSH/PUT alternating
    // starting with FLUSH; with a zero gap the handshakes are 5 cycles apart.
    task automatic test_priority_order();
        step();
        interpkt_gap_cycles = '0;
        kv_ready     = 1'b1;
        start_update = 1'b1;
        hs_times.delete();
        tq.push_back(32'hA1A1_0001);
        fq.push_back(64'hF000_0001_0000_00F1);
        fq.push_back(64'hF000_0002_0000_00F2);
        pq.push_back(64'hB000_0001_0000_00B1);
        pq.push_back(64'hB000_0002_0000_00B2);
        expect_rec(32'h0, 32'hA1A1_0001, 2'd3);
        expect_rec(32'hF000_0001, 32'h0000_00F1, 2'd2);
        expect_rec(32'hB000_0001, 32'h0000_00B1, 2'd1);
        expect_rec(32'hF000_0002, 32'h0000_00F2, 2'd2);
        expect_rec(32'hB000_0002, 32'h0000_00B2, 2'd1);
        drain("priority_order");
        tests++;
        if (hs_times.size() != 5) begin
            fails++;
            $display("[TB] FAIL priority_hs_count: got %0d, required 5", hs_times.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                tests++;
                if (hs_times[i] - hs_times[i-1] != 5) begin
                    fails++;
                    $display("[TB] FAIL priority_hs_spacing[%0d]: got %0d, required 5", i, hs_times[i] - hs_times[i-1]);
                end
            end
        end
        tests++;
        if (grant_cnt_tcheck !== 4'd1 || grant_cnt_flush !== 4'd2 || grant_cnt_put !== 4'd2) begin
            fails++;
            $display("[TB] FAIL priority_counters: got t=%0d f=%0d p=%0d, required 1 2 2",
                     grant_cnt_tcheck, grant_cnt_flush, grant_cnt_put);
        end
    endtask

    task automatic test_put_enable();
        int seen = 0;
        step();
        start_update = 1'b0;
        pq.push_back(64'h0000_0005_0000_0007);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (put_rdreq || busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("[TB] FAIL put_disabled: got %0d active cycles, required 0", seen);
        end
        step();
        start_update = 1'b1;
        expect_rec(32'h5, 32'h7, 2'd1);
        drain("put_enable");
    endtask

    task automatic test_gap_hold();
        int hs;
        int n = 0;
        step();
        interpkt_gap_cycles = 32'd10;
        kv_ready = 1'b0;
        hs_times.delete();
        fq.push_back(64'hCAFE_0001_DEAD_0001);
        fq.push_back(64'hCAFE_0002_DEAD_0002);
        expect_rec(32'hCAFE_0001, 32'hDEAD_0001, 2'd2);
        expect_rec(32'hCAFE_0002, 32'hDEAD_0002, 2'd2);
        wait_valid("gap_hold");
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (kv_valid !== 1'b1 || kv_key !== 32'hCAFE_0001 || kv_val !== 32'hDEAD_0001 || kv_select !== 2'd2) begin
                fails++;
                $display("[TB] FAIL gap_hold_stable[%0d]: got valid=%b key=%h val=%h sel=%0d, required 1 cafe0001 dead0001 2",
                         i, kv_valid, kv_key, kv_val, kv_select);
            end
            if (i < 2) @(negedge clk);
        end
        step();
        kv_ready = 1'b1;
        @(negedge clk);
        while (!flush_rdreq && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!flush_rdreq || hs_times.size() == 0) begin
            fails++;
            $display("[TB] FAIL gap_next_rdreq: got rdreq=%b handshakes=%0d, required rdreq after one handshake",
                     flush_rdreq, hs_times.size());
        end else begin
            hs = hs_times[hs_times.size()-1];
            tests++;
            if (cyc - hs != 13) begin
                fails++;
                $display("[TB] FAIL gap_length: got rdreq %0d cycles after handshake, required 13", cyc - hs);
            end
        end
        drain("gap_hold");
        interpkt_gap_cycles = '0;
    endtask

    task automatic test_tcheck_no_preempt();
        step();
        kv_ready     = 1'b0;
        start_update = 1'b1;
        pq.push_back(64'hAAAA_0001_BBBB_0002);
        expect_rec(32'hAAAA_0001, 32'hBBBB_0002, 2'd1);
        wait_valid("no_preempt");
        step();
        tq.push_back(32'h1234_5678);
        expect_rec(32'h0, 32'h1234_5678, 2'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (kv_valid !== 1'b1 || kv_select !== 2'd1 || tcheck_rdreq !== 1'b0) begin
                fails++;
                $display("[TB] FAIL no_preempt_hold[%0d]: got valid=%b sel=%0d t_rdreq=%b, required 1 1 0",
                         i, kv_valid, kv_select, tcheck_rdreq);
            end
        end
        step();
        kv_ready = 1'b1;
        drain("no_preempt");
    endtask

    // FLUSH is left in OFFER (so the bulk history says FLUSH) and then reset;
    // the next FLUSH/PUT tie must still go to FLUSH.
    task automatic test_reset_in_offer();
        step();
        kv_ready = 1'b0;
        fq.push_back(64'h1111_0000_1111_0000);
        fq.push_back(64'h2222_0000_2222_0000);
        pq.push_back(64'h3333_0000_3333_0000);
        wait_valid("reset_offer");
        tests++;
        if (kv_select !== 2'd2) begin
            fails++;
            $display("[TB] FAIL reset_offer_sel: got %0d, required 2", kv_select);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_offer");
        expect_rec(32'h2222_0000, 32'h2222_0000, 2'd2);
        expect_rec(32'h3333_0000, 32'h3333_0000, 2'd1);
        step();
        kv_ready = 1'b1;
        drain("reset_offer");
    endtask

    task automatic test_saturation();
        step();
        start_update = 1'b1;
        kv_ready     = 1'b1;
        interpkt_gap_cycles = '0;
        for (int i = 0; i < 16; i++) begin
            pq.push_back({32'h5A00_0000 + i, 32'h0000_0100 + i});
            expect_rec(32'h5A00_0000 + i, 32'h0000_0100 + i, 2'd1);
        end
        drain("saturation");
        tests++;
        if (grant_cnt_put !== 4'd15) begin
            fails++;
            $display("[TB] FAIL sat_put: got %0d, required 15", grant_cnt_put);
        end
        tests++;
        if (grant_cnt_flush !== 4'd1 || grant_cnt_tcheck !== 4'd0) begin
            fails++;
            $display("[TB] FAIL sat_others: got f=%0d t=%0d, required 1 0", grant_cnt_flush, grant_cnt_tcheck);
        end
    endtask

    initial begin
        fork
            fifo_model();
            monitor();
        join_none
        test_reset();
        test_priority_order();
        test_put_enable();
        test_gap_hold();
        test_tcheck_no_preempt();
        test_reset_in_offer();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_source_scheduler.md
Name: tx_source_scheduler

Overview:
Schedules the single UDP packet composer between three KV sources:
- TCHECK: iteration accumulate-value FIFO
- FLUSH: DRAM flush FIFO
- PUT: TX external update FIFO

It pops one entry from the winning source FIFO and presents one {key,val,select} record to the composer. After the composer accepts the record, it enforces the programmable inter-packet gap before the next grant. It sits between the three source FIFOs and the composer input, replacing the composer's inline priority decoder and timeout logic.

Parameters:
KEY_WIDTH, 32, key field width
VAL_WIDTH, 32, value field width
GAP_WIDTH, 32, inter-packet gap counter width
STAT_WIDTH, 32, per-source grant counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tcheck_q  in  32  accum FIFO data, valid the cycle after tcheck_rdreq
tcheck_empty  in  1  accum FIFO empty
tcheck_rdreq  out  1  accum FIFO pop
flush_q  in  64  DRAM FIFO data {key,val}, 1-cycle read latency
flush_empty  in  1  DRAM FIFO empty
flush_rdreq  out  1  DRAM FIFO pop
put_q  in  64  TX update FIFO data {key,val}, 1-cycle read latency
put_empty  in  1  TX update FIFO empty
put_rdreq  out  1  TX update FIFO pop
start_update  in  1  PUT enable level
interpkt_gap_cycles  in  GAP_WIDTH  gap length, sampled on handshake
kv_valid  out  1  record valid to composer
kv_ready  in  1  composer accepts record
kv_key  out  KEY_WIDTH  record key
kv_val  out  VAL_WIDTH  record value
kv_select  out  2  record type: 1=PUT, 2=FLUSH, 3=TCHECK, 0=none
busy  out  1  high in any state other than IDLE
grant_cnt_tcheck / grant_cnt_flush / grant_cnt_put  out  STAT_WIDTH  saturating grant counters

Behaviour:
- Reset (synchronous, active-high, clk domain):
  - state=IDLE.
  - All rdreq=0, kv_valid=0, kv_key=0, kv_val=0, kv_select=0, busy=0.
  - Grant counters=0, gap counter=0, last_bulk=PUT (so FLUSH wins the first bulk tie).
  - Reset asserted in any state aborts the operation. A popped-but-unpresented entry is discarded.
- Request terms:
  - req_t = !tcheck_empty
  - req_f = !flush_empty
  - req_p = !put_empty & start_update
- IDLE:
  - Grant in priority order: TCHECK first. Otherwise, if req_f and req_p are both high, grant the source opposite last_bulk; otherwise grant whichever of the two is requesting.
  - On a grant, latch kv_select and update last_bulk (FLUSH/PUT grants only), then go to READ.
  - With no request, stay in IDLE.
- READ: assert exactly the granted rdreq for this one cycle, then go to CAPTURE.
- CAPTURE: latch the record, then go to OFFER.
  - TCHECK: kv_key=0, kv_val=tcheck_q.
  - FLUSH / PUT: kv_key=q[63:32], kv_val=q[31:0].
- OFFER:
  - kv_valid=1; kv_key, kv_val and kv_select are held stable until kv_ready.
  - On kv_valid&kv_ready: load gap counter with interpkt_gap_cycles, increment the granted source's counter (saturating at all-ones), go to GAP.
- GAP:
  - kv_valid=0.
  - Counter decrements each cycle; exit to IDLE in the cycle the counter reads 0.
  - Total GAP occupancy is N+1 cycles for a loaded value N; N=0 gives 1 cycle.
- Latency:
  - Grant decision to rdreq: 1 cycle. rdreq to kv_valid: 2 cycles.
  - Minimum period between consecutive handshakes: 4 + (N+1) cycles.
- Boundary conditions:
  - A request arriving during READ, CAPTURE, OFFER or GAP never preempts the current record; it is evaluated at the next IDLE.
  - start_update falling after a PUT grant does not cancel it; the PUT record completes.
  - A FIFO going empty after the grant is a source error. The scheduler still completes with the FIFO's q value.
  - At most one rdreq is high in any cycle. No rdreq is high outside READ.
  - kv_select is 0 in IDLE and in GAP.

Decomposition:
- Select encodings (PUT/FLUSH/TCHECK) and state encodings go in the shared command_defines include, used by both the scheduler and the composer.
- One sub-module: interpkt_gap_timer (load, count-down, zero flag, GAP_WIDTH wide).

Test Plan:
1. All FIFOs non-empty, start_update=1, gap=0, kv_ready tied high -> grant order TCHECK, FLUSH, PUT, FLUSH, PUT... Handshakes are exactly 5 cycles apart.
2. put_q=0x0000000500000007, only PUT non-empty, start_update=0 for 20 cycles then 1 -> no rdreq while start_update=0. Then kv_key=5, kv_val=7, kv_select=1.
3. gap=10, back-to-back FLUSH entries, kv_ready held low for 3 cycles in OFFER -> kv fields stable for all 3 cycles. Next flush_rdreq occurs exactly 11 GAP cycles plus 1 IDLE cycle after the handshake.
4. tcheck_q=0x12345678 arrives while a PUT is in OFFER -> the PUT completes first. The next record is key=0, val=0x12345678, select=3.
5. reset asserted for one cycle during OFFER -> next cycle all outputs are at reset values. The next grant, with FLUSH and PUT both pending, goes to FLUSH.
6. Grant counter forced near all-ones by 2^STAT_WIDTH grants (STAT_WIDTH=4 override) -> grant_cnt_put saturates at 15 and does not wrap.
